// File: rtl/bp_io_cce_req_arbiter.sv
// ---------------------------------------------------------------------------
// bp_io_cce_req_arbiter
//
// Purpose:
//   Several LCE request sources share one uncached-request input of the I/O
//   CCE through this block. It picks one requester per cycle in round-robin
//   order and places that message in a one-entry registered buffer facing the
//   I/O CCE. Each requester has a limited number of in-flight requests
//   (credits). Completions coming back from the I/O CCE return those credits.
//   The block also reports when it is fully quiescent, which fences use.
//
// Ports:
//   clk_i           in   clock; all state updates on the rising edge
//   reset_n_i       in   asynchronous active-low reset
//   req_i           in   num_req_p packed request messages (slice i = requester i)
//   req_v_i         in   per-requester request valid
//   req_yumi_o      out  one-hot-or-zero; the message of that requester is taken now
//   lce_req_o       out  buffered message toward the I/O CCE
//   lce_req_v_o     out  buffer holds a valid message
//   lce_req_yumi_i  in   I/O CCE consumes lce_req_o this cycle
//   done_v_i        in   one completion returned to an LCE
//   done_lce_id_i   in   destination LCE of the completion (low bits = requester)
//   idle_o          out  buffer empty and no requester has anything outstanding
//   error_o         out  sticky; completion seen for a requester with nothing outstanding
// ---------------------------------------------------------------------------
module bp_io_cce_req_arbiter #(
    parameter int num_req_p         = 4,
    parameter int msg_width_p       = 600,
    parameter int lce_id_width_p    = 4,
    parameter int max_outstanding_p = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0]   req_i,
    input  logic [num_req_p-1:0]               req_v_i,
    output logic [num_req_p-1:0]               req_yumi_o,
    output logic [msg_width_p-1:0]             lce_req_o,
    output logic                               lce_req_v_o,
    input  logic                               lce_req_yumi_i,
    input  logic                               done_v_i,
    input  logic [lce_id_width_p-1:0]          done_lce_id_i,
    output logic                               idle_o,
    output logic                               error_o
);

    localparam int idx_w = $clog2(num_req_p);
    localparam int cnt_w = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_w-1:0] max_cnt = cnt_w'(max_outstanding_p);

    // Output buffer states
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]             state_r;
    logic [0:0]             state_n;
    logic [idx_w-1:0]       rr_ptr_r;
    logic [msg_width_p-1:0] buf_msg_r;
    logic                   error_r;

    logic [msg_width_p-1:0] req_slice [num_req_p];
    logic [num_req_p-1:0]   eligible;
    logic [num_req_p-1:0]   inc;
    logic [num_req_p-1:0]   dec;
    logic [num_req_p-1:0]   zero_done;
    logic [num_req_p-1:0]   nonzero;

    logic                   can_accept;
    logic                   any_hit;
    logic                   grant;
    logic [idx_w-1:0]       winner;
    logic [idx_w-1:0]       cand;
    logic [idx_w-1:0]       done_idx;

    // Only the low bits of the LCE id select the requester; the rest is ignored.
    assign done_idx = done_lce_id_i[idx_w-1:0];

    generate
        if (lce_id_width_p > idx_w) begin : g_id_hi
            logic unused_done_id_hi;
            assign unused_done_id_hi = ^done_lce_id_i[lce_id_width_p-1:idx_w];
        end
    endgenerate

    // Per-requester slice, credit counter and the eligibility/credit events.
    // A requester is eligible only while it still has a credit left, so a
    // counter can never be pushed past max_outstanding_p. Eligibility reads
    // the registered counter, so a returned credit is usable next cycle.
    generate
        for (genvar g = 0; g < num_req_p; g++) begin : g_req
            logic [cnt_w-1:0] cnt_r;

            assign req_slice[g] = req_i[g*msg_width_p +: msg_width_p];
            assign eligible[g]  = req_v_i[g] & (cnt_r < max_cnt);
            assign inc[g]       = grant & (winner == idx_w'(g));
            assign dec[g]       = done_v_i & (done_idx == idx_w'(g));
            assign zero_done[g] = dec[g] & (cnt_r == '0);
            assign nonzero[g]   = (cnt_r != '0);

            // A grant and a completion in the same cycle cancel out. A
            // completion with nothing outstanding leaves the counter at zero
            // and is flagged through error_r instead.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    cnt_r <= '0;
                end else if (inc[g] && !dec[g]) begin
                    cnt_r <= cnt_r + cnt_w'(1);
                end else if (dec[g] && !inc[g] && (cnt_r != '0)) begin
                    cnt_r <= cnt_r - cnt_w'(1);
                end
            end
        end
    endgenerate

    // The buffer can take a new message when it is empty, or when its current
    // message leaves this same cycle, which gives back-to-back throughput.
    assign can_accept = (state_r == EMPTY) | lce_req_yumi_i;

    // Round-robin scan starting just after the last winner. Offset num_req_p
    // wraps to the last winner itself, so it is checked last. num_req_p is a
    // power of two, so truncating the sum gives the modulo for free.
    always_comb begin
        any_hit = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            cand = rr_ptr_r + idx_w'(k);
            if (!any_hit && eligible[cand]) begin
                any_hit = 1'b1;
                winner  = cand;
            end
        end
    end

    // No message is consumed while reset is held, even when requests are valid.
    assign grant = reset_n_i & can_accept & any_hit;

    always_comb begin
        req_yumi_o = '0;
        if (grant) begin
            req_yumi_o[winner] = 1'b1;
        end
    end

    // Buffer occupancy: fill on grant, drain on yumi unless refilled.
    always_comb begin
        state_n = state_r;
        case (state_r)
            EMPTY: begin
                if (grant) begin
                    state_n = FULL;
                end
            end
            FULL: begin
                if (lce_req_yumi_i && !grant) begin
                    state_n = EMPTY;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    // Control state: buffer occupancy, round-robin pointer and sticky error.
    // The pointer starts at the last index so requester 0 wins first.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= EMPTY;
            rr_ptr_r <= idx_w'(num_req_p - 1);
            error_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            if (grant) begin
                rr_ptr_r <= winner;
            end
            if (|zero_done) begin
                error_r <= 1'b1;
            end
        end
    end

    // Message payload. Its contents only matter while FULL, so it carries no
    // reset; it is written only on a grant and otherwise holds steady.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            buf_msg_r <= req_slice[winner];
        end
    end

    assign lce_req_o   = buf_msg_r;
    assign lce_req_v_o = (state_r == FULL);
    assign idle_o      = (state_r == EMPTY) & ~(|nonzero);
    assign error_o     = error_r;

endmodule

// File: tb/tb_bp_io_cce_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bp_io_cce_req_arbiter
//
// Directed and randomized test of the request arbiter. The bench keeps its
// own view of the arbiter: whether the buffer is full and what it holds, the
// last winner, the in-flight count of each requester and the sticky error.
// Every cycle it works out from that view which requester should be consumed,
// then compares the DUT outputs with it.
// ---------------------------------------------------------------------------
module tb_bp_io_cce_req_arbiter;

    localparam int N    = 4;
    localparam int W    = 64;
    localparam int ID   = 4;
    localparam int MAXO = 2;

    logic             clk_i;
    logic             reset_n_i;
    logic [N*W-1:0]   req_i;
    logic [N-1:0]     req_v_i;
    logic [N-1:0]     req_yumi_o;
    logic [W-1:0]     lce_req_o;
    logic             lce_req_v_o;
    logic             lce_req_yumi_i;
    logic             done_v_i;
    logic [ID-1:0]    done_lce_id_i;
    logic             idle_o;
    logic             error_o;

    int checks   = 0;
    int failures = 0;

    // Reference view of the arbiter
    bit         m_full;
    logic [W-1:0] m_msg;
    int         m_rr;
    int         m_cnt [N];
    bit         m_err;

    bp_io_cce_req_arbiter #(
        .num_req_p         (N),
        .msg_width_p       (W),
        .lce_id_width_p    (ID),
        .max_outstanding_p (MAXO)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .req_i          (req_i),
        .req_v_i        (req_v_i),
        .req_yumi_o     (req_yumi_o),
        .lce_req_o      (lce_req_o),
        .lce_req_v_o    (lce_req_v_o),
        .lce_req_yumi_i (lce_req_yumi_i),
        .done_v_i       (done_v_i),
        .done_lce_id_i  (done_lce_id_i),
        .idle_o         (idle_o),
        .error_o        (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hard stop in case something stalls the sequence
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_msg  = '0;
        m_rr   = N - 1;
        m_err  = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    function automatic bit model_idle();
        int sum = 0;
        for (int i = 0; i < N; i++) sum += m_cnt[i];
        return !m_full && (sum == 0);
    endfunction

    // First valid requester with a credit left, scanning after the last winner
    function automatic int pick();
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (m_rr + k) % N;
            if (req_v_i[idx] && (m_cnt[idx] < MAXO)) return idx;
        end
        return -1;
    endfunction

    // Drive one cycle's inputs; yumi is only offered while the buffer is full
    task automatic apply_stimulus(input logic [N-1:0] v, input bit want_yumi,
                                  input bit dv, input int did);
        req_v_i        = v;
        lce_req_yumi_i = want_yumi & m_full;
        done_v_i       = dv;
        done_lce_id_i  = ID'(did);
        for (int i = 0; i < N; i++) req_i[i*W +: W] = {$urandom(), $urandom()};
    endtask

    // Check outputs against the reference, clock once, then advance the reference
    task automatic run_cycle();
        int w;
        int di;
        bit can;
        logic [N-1:0] exp_yumi;
        logic [W-1:0] granted_msg;
        #1;
        can      = !m_full || (lce_req_yumi_i === 1'b1);
        w        = can ? pick() : -1;
        exp_yumi = (w >= 0) ? N'(1 << w) : '0;
        check_output("req_yumi", W'(req_yumi_o), W'(exp_yumi));
        check_output("lce_req_v", W'(lce_req_v_o), W'(m_full));
        if (m_full) check_output("lce_req_msg", lce_req_o, m_msg);
        check_output("idle", W'(idle_o), W'(model_idle()));
        check_output("error", W'(error_o), W'(m_err));
        granted_msg = (w >= 0) ? req_i[w*W +: W] : '0;
        di = int'(done_lce_id_i) % N;
        @(posedge clk_i);
        if (w >= 0) begin
            m_full = 1'b1;
            m_msg  = granted_msg;
            m_rr   = w;
        end else if (lce_req_yumi_i) begin
            m_full = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            bit inc = (w == i);
            bit dec = done_v_i && (di == i);
            if (dec && m_cnt[i] == 0) m_err = 1'b1;
            if (inc && !dec) m_cnt[i]++;
            else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
        end
        #2;
    endtask

    // Return every outstanding credit and empty the buffer
    task automatic drain();
        int id;
        for (int n = 0; n < 40 && !model_idle(); n++) begin
            id = -1;
            for (int i = N - 1; i >= 0; i--) if (m_cnt[i] > 0) id = i;
            apply_stimulus('0, 1'b1, id >= 0, (id >= 0) ? id : 0);
            run_cycle();
        end
        apply_stimulus('0, 1'b0, 1'b0, 0);
        run_cycle();
        check_output("drain_idle", W'(idle_o), W'(1));
    endtask

    initial begin
        int id;
        logic [W-1:0] held;

        // Reset values before any clock edge
        reset_n_i = 1'b0;
        model_reset();
        apply_stimulus('0, 1'b0, 1'b0, 0);
        #3;
        check_output("rst_lce_req_v", W'(lce_req_v_o), W'(0));
        check_output("rst_req_yumi", W'(req_yumi_o), W'(0));
        check_output("rst_idle", W'(idle_o), W'(1));
        check_output("rst_error", W'(error_o), W'(0));
        @(posedge clk_i);
        #2;
        reset_n_i = 1'b1;

        // Single requester 2: consumed at once, visible next cycle, credit back on done
        apply_stimulus(4'b0100, 1'b1, 1'b0, 0);
        held = req_i[2*W +: W];
        #1;
        check_output("single_yumi", W'(req_yumi_o), W'(4'b0100));
        run_cycle();
        apply_stimulus('0, 1'b1, 1'b0, 0);
        #1;
        check_output("single_msg", lce_req_o, held);
        check_output("single_not_idle", W'(idle_o), W'(0));
        run_cycle();
        apply_stimulus('0, 1'b0, 1'b1, 2);
        run_cycle();
        apply_stimulus('0, 1'b0, 1'b0, 0);
        run_cycle();

        // All requesters valid, continuous yumi, done for the previous winner
        for (int c = 0; c < 12; c++) begin
            id = m_rr;
            apply_stimulus(4'b1111, 1'b1, m_cnt[id] > 0, id);
            run_cycle();
            check_output("rr_no_bubble", W'(lce_req_v_o), W'(1));
        end
        drain();

        // Credit limit on requester 1, then resume after one done
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(4'b0010, 1'b1, 1'b0, 0);
            run_cycle();
        end
        check_output("credit_blocked", W'(req_yumi_o), W'(0));
        apply_stimulus(4'b0010, 1'b1, 1'b1, 1);
        run_cycle();
        apply_stimulus(4'b0010, 1'b1, 1'b0, 0);
        #1;
        check_output("credit_resume", W'(req_yumi_o), W'(4'b0010));
        run_cycle();
        drain();

        // Backpressure: buffer held while the I/O CCE stalls
        apply_stimulus(4'b0001, 1'b0, 1'b0, 0);
        run_cycle();
        held = m_msg;
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(4'b1000, 1'b0, 1'b0, 0);
            run_cycle();
        end
        check_output("bp_msg_stable", lce_req_o, held);
        apply_stimulus(4'b1000, 1'b1, 1'b0, 0);
        run_cycle();
        check_output("bp_refill_v", W'(lce_req_v_o), W'(1));
        drain();

        // Grant and done to requester 3 in one cycle leave its count at one,
        // so exactly one more grant fits before the limit
        apply_stimulus(4'b1000, 1'b1, 1'b0, 0);
        run_cycle();
        apply_stimulus(4'b1000, 1'b1, 1'b1, 3);
        run_cycle();
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(4'b1000, 1'b1, 1'b0, 0);
            run_cycle();
        end
        drain();

        // Completion with nothing outstanding: sticky error
        apply_stimulus('0, 1'b0, 1'b1, 0);
        run_cycle();
        for (int c = 0; c < 3; c++) begin
            apply_stimulus('0, 1'b0, 1'b0, 0);
            run_cycle();
        end
        check_output("error_sticky", W'(error_o), W'(1));

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            id = int'($urandom_range(0, N - 1));
            apply_stimulus(N'($urandom()), ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 2) == 0) && (m_cnt[id] > 0),
                           int'({2'($urandom()), 2'(id)}));
            run_cycle();
        end

        // Asynchronous reset with the buffer full
        apply_stimulus(4'b1111, 1'b0, 1'b0, 0);
        run_cycle();
        apply_stimulus(4'b1111, 1'b0, 1'b0, 0);
        run_cycle();
        reset_n_i = 1'b0;
        #1;
        check_output("async_rst_v", W'(lce_req_v_o), W'(0));
        check_output("async_rst_error", W'(error_o), W'(0));
        check_output("async_rst_idle", W'(idle_o), W'(1));
        check_output("async_rst_yumi", W'(req_yumi_o), W'(0));
        model_reset();
        @(posedge clk_i);
        #2;
        reset_n_i = 1'b1;
        apply_stimulus(4'b1111, 1'b0, 1'b0, 0);
        #1;
        check_output("post_rst_first", W'(req_yumi_o), W'(4'b0001));
        run_cycle();
        apply_stimulus('0, 1'b1, 1'b0, 0);
        run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
